// File: rtl/branch_ctrl_pkg.sv
// Shared constants and types for the branch controller and its update FIFO.
package branch_ctrl_pkg;

    localparam int DATA_WID = 32;

    // Recovery sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        REDIR = 2'd2
    } bctrl_state_t;

    // One predictor-update record.
    typedef struct packed {
        logic [DATA_WID-1:0] pc;
        logic                taken;
        logic [DATA_WID-1:0] target;
    } bru_upd_t;

    // A branch is mispredicted when the direction differs, or when it was
    // taken to a target other than the one fetch guessed.
    function automatic logic is_mispredict(
        input logic                taken,
        input logic [DATA_WID-1:0] target,
        input logic                p_taken,
        input logic [DATA_WID-1:0] p_target
    );
        return (taken != p_taken) || (taken && (target != p_target));
    endfunction

endpackage

// File: rtl/branch_ctrl_fifo.sv
// Predictor-update FIFO. Pointers carry one extra wrap bit so that full and
// empty are told apart by comparing the MSB and the index bits.
module bru_upd_fifo
    import branch_ctrl_pkg::*;
#(
    parameter int UPD_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_valid,
    input  bru_upd_t push_data,
    input  logic     pop_ready,
    output logic     full,
    output logic     empty,
    output bru_upd_t head
);

    localparam int AW = $clog2(UPD_DEPTH);

    bru_upd_t      mem_r [UPD_DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic          push_s;
    logic          pop_s;

    assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty  = (wr_ptr_r == rd_ptr_r);
    assign push_s = push_valid && !full;
    assign pop_s  = pop_ready && !empty;
    assign head   = mem_r[rd_ptr_r[AW-1:0]];

    // Advance write/read pointers; reset discards every stored entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: detects mispredicts, sequences flush then
// fetch redirect, and queues every resolved branch for predictor update.
// Optional feature macro: BRANCH_CTRL_STAT_EN enables branch/mispredict counters.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int UPD_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                br_valid,
    output logic                br_ready,
    input  logic [DATA_WID-1:0] br_pc,
    input  logic                br_taken,
    input  logic [DATA_WID-1:0] br_target,
    input  logic                pred_taken,
    input  logic [DATA_WID-1:0] pred_target,
    output logic                flush,
    output logic                redirect_valid,
    input  logic                redirect_ready,
    output logic [DATA_WID-1:0] redirect_pc,
    output logic                upd_valid,
    input  logic                upd_ready,
    output logic [DATA_WID-1:0] upd_pc,
    output logic                upd_taken,
    output logic [DATA_WID-1:0] upd_target,
    output logic [DATA_WID-1:0] stat_br,
    output logic [DATA_WID-1:0] stat_mis
);

    bctrl_state_t        state_r;
    bctrl_state_t        next_state_s;
    logic                flush_r;
    logic                redirect_valid_r;
    logic [DATA_WID-1:0] redirect_pc_r;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                br_fire_s;
    logic                mispredict_s;
    bru_upd_t            push_data_s;
    bru_upd_t            head_s;

    assign br_ready     = (state_r == IDLE) && !fifo_full_s;
    assign br_fire_s    = br_valid && br_ready;
    assign mispredict_s = is_mispredict(br_taken, br_target, pred_taken, pred_target);
    assign push_data_s  = '{pc: br_pc, taken: br_taken, target: br_target};

    assign flush          = flush_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign upd_valid      = !fifo_empty_s;
    assign upd_pc         = head_s.pc;
    assign upd_taken      = head_s.taken;
    assign upd_target     = head_s.target;

    bru_upd_fifo #(
        .UPD_DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (br_fire_s),
        .push_data  (push_data_s),
        .pop_ready  (upd_ready),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .head       (head_s)
    );

    // Next-state logic for the mispredict recovery sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (br_fire_s && mispredict_s) begin
                    next_state_s = FLUSH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FLUSH: begin
                next_state_s = REDIR;
            end
            REDIR: begin
                if (redirect_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = REDIR;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register plus registered flush/redirect outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= IDLE;
            flush_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= '0;
        end else begin
            state_r          <= next_state_s;
            flush_r          <= (next_state_s == FLUSH);
            redirect_valid_r <= (next_state_s == REDIR);
            if (br_fire_s && mispredict_s) begin
                redirect_pc_r <= br_target;
            end
        end
    end

`ifdef BRANCH_CTRL_STAT_EN
    logic [DATA_WID-1:0] stat_br_r;
    logic [DATA_WID-1:0] stat_mis_r;

    // Free-running (wrapping) counters of accepted branches and mispredicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_r  <= '0;
            stat_mis_r <= '0;
        end else if (br_fire_s) begin
            stat_br_r <= stat_br_r + 32'd1;
            if (mispredict_s) begin
                stat_mis_r <= stat_mis_r + 32'd1;
            end
        end
    end

    assign stat_br  = stat_br_r;
    assign stat_mis = stat_mis_r;
`else
    assign stat_br  = 32'd0;
    assign stat_mis = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl (UPD_DEPTH = 4).
module tb_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic        br_ready;
    logic [31:0] br_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] stat_br;
    logic [31:0] stat_mis;

    int n_chk;
    int n_fail;
    logic [31:0] exp_br;
    logic [31:0] exp_mis;

    branch_ctrl #(.UPD_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_pc          (br_pc),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .stat_br        (stat_br),
        .stat_mis       (stat_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        br_valid    = 1'b1;
        br_pc       = pc;
        br_taken    = tk;
        br_target   = tgt;
        pred_taken  = ptk;
        pred_target = ptgt;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        br_valid = 1'b0;
        br_pc = 32'h0;
        br_taken = 1'b0;
        br_target = 32'h0;
        pred_taken = 1'b0;
        pred_target = 32'h0;
        redirect_ready = 1'b0;
        upd_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_br_ready", br_ready, 1);
        chk("rst_flush", flush, 0);
        chk("rst_redir_valid", redirect_valid, 0);
        chk("rst_redir_pc", redirect_pc, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_stat_br", stat_br, 0);
        chk("rst_stat_mis", stat_mis, 0);

        // Correct prediction
        drive_br(32'h100, 1'b1, 32'h140, 1'b1, 32'h140);
        chk("ok_br_ready_pre", br_ready, 1);
        step();
        br_valid = 1'b0;
        chk("ok_flush", flush, 0);
        chk("ok_br_ready", br_ready, 1);
        chk("ok_upd_valid", upd_valid, 1);
        chk("ok_upd_pc", upd_pc, 32'h100);
        chk("ok_upd_taken", upd_taken, 1);
        chk("ok_upd_target", upd_target, 32'h140);
        step();
        chk("ok_flush2", flush, 0);
        chk("ok_redir2", redirect_valid, 0);
        upd_ready = 1'b1;
        step();
        chk("ok_drained", upd_valid, 0);

        // Direction mispredict, redirect accepted immediately
        redirect_ready = 1'b1;
        drive_br(32'h200, 1'b0, 32'h204, 1'b1, 32'h240);
        step();
        br_valid = 1'b0;
        chk("dir_flush_t1", flush, 1);
        chk("dir_redir_t1", redirect_valid, 0);
        chk("dir_br_ready_t1", br_ready, 0);
        step();
        chk("dir_flush_t2", flush, 0);
        chk("dir_redir_t2", redirect_valid, 1);
        chk("dir_redir_pc_t2", redirect_pc, 32'h204);
        step();
        chk("dir_redir_t3", redirect_valid, 0);
        chk("dir_br_ready_t3", br_ready, 1);

        // Target mispredict with redirect_ready stalled for 5 cycles
        redirect_ready = 1'b0;
        drive_br(32'h2f0, 1'b1, 32'h300, 1'b1, 32'h280);
        step();
        br_valid = 1'b0;
        chk("tgt_flush_t1", flush, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("tgt_stall_flush", flush, 0);
            chk("tgt_stall_redir", redirect_valid, 1);
            chk("tgt_stall_pc", redirect_pc, 32'h300);
            chk("tgt_stall_br_ready", br_ready, 0);
        end
        redirect_ready = 1'b1;
        step();
        chk("tgt_done_redir", redirect_valid, 0);
        chk("tgt_done_br_ready", br_ready, 1);
        chk("tgt_done_flush", flush, 0);

        // Full FIFO and wrap-around order
        upd_ready = 1'b0;
        chk("full_start_empty", upd_valid, 0);
        for (int i = 0; i < 4; i++) begin
            drive_br(32'h400 + 32'(i * 4), 1'b0, 32'h404 + 32'(i * 4), 1'b0, 32'h404 + 32'(i * 4));
            chk("full_fill_ready", br_ready, 1);
            step();
        end
        drive_br(32'h410, 1'b0, 32'h414, 1'b0, 32'h414);
        chk("full_5th_ready", br_ready, 0);
        step();
        chk("full_5th_ready_hold", br_ready, 0);
        chk("full_head", upd_pc, 32'h400);
        upd_ready = 1'b1;
        step();
        upd_ready = 1'b0;
        chk("full_reopen", br_ready, 1);
        step();
        br_valid = 1'b0;
        chk("full_again", br_ready, 0);
        upd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("wrap_valid", upd_valid, 1);
            chk("wrap_pc", upd_pc, 32'h404 + 32'(i * 4));
            chk("wrap_target", upd_target, 32'h408 + 32'(i * 4));
            step();
        end
        chk("wrap_empty", upd_valid, 0);

        // Two more branches: one correct, one mispredict (10 total, 3 mispredicted)
        drive_br(32'h500, 1'b1, 32'h520, 1'b1, 32'h520);
        step();
        drive_br(32'h504, 1'b1, 32'h600, 1'b0, 32'h508);
        chk("mis3_ready", br_ready, 1);
        step();
        br_valid = 1'b0;
        chk("mis3_flush", flush, 1);
        step();
        chk("mis3_redir_pc", redirect_pc, 32'h600);
        step();
        chk("mis3_idle", br_ready, 1);
`ifdef BRANCH_CTRL_STAT_EN
        exp_br  = 32'd10;
        exp_mis = 32'd3;
`else
        exp_br  = 32'd0;
        exp_mis = 32'd0;
`endif
        chk("stat_br", stat_br, exp_br);
        chk("stat_mis", stat_mis, exp_mis);

        // Reset pulse during REDIR
        upd_ready = 1'b0;
        redirect_ready = 1'b0;
        drive_br(32'h700, 1'b0, 32'h704, 1'b1, 32'h740);
        step();
        br_valid = 1'b0;
        step();
        chk("rr_redir_before", redirect_valid, 1);
        chk("rr_upd_before", upd_valid, 1);
        rst = 1'b1;
        #1;
        chk("rr_redir_now", redirect_valid, 0);
        chk("rr_upd_now", upd_valid, 0);
        chk("rr_flush_now", flush, 0);
        chk("rr_pc_now", redirect_pc, 0);
        chk("rr_stat_br", stat_br, 0);
        step();
        rst = 1'b0;
        step();
        chk("rr_br_ready", br_ready, 1);
        chk("rr_redir_after", redirect_valid, 0);
        chk("rr_flush_after", flush, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter UPD_DEPTH, default 4, update-FIFO depth; power of two, at least 2.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 br_valid  in  1  resolved branch or jump from the branch unit (op != NOP).
REQ-005 br_ready  out  1  branch_ctrl accepts; transfer occurs when br_valid & br_ready.
REQ-006 br_pc  in  32  PC of the branch.
REQ-007 br_taken  in  1  actual direction.
REQ-008 br_target  in  32  actual next PC: pc+imm if taken, pc+4 otherwise.
REQ-009 pred_taken  in  1  direction predicted at fetch.
REQ-010 pred_target  in  32  next PC predicted at fetch.
REQ-011 flush  out  1  kill younger in-flight instructions.
REQ-012 redirect_valid  out  1  fetch PC override request.
REQ-013 redirect_ready  in  1  fetch accepts redirect_pc.
REQ-014 redirect_pc  out  32  corrected fetch PC.
REQ-015 upd_valid  out  1  predictor-update entry available.
REQ-016 upd_ready  in  1  predictor consumes the entry.
REQ-017 upd_pc, upd_taken, upd_target  out  32/1/32  head-entry fields.
REQ-018 stat_br, stat_mis  out  32 each  branch and mispredict counters.

Function
REQ-019 Mispredict, evaluated on an accepted branch, is br_taken != pred_taken, or br_taken with br_target != pred_target.
REQ-020 The FSM has three states, IDLE, FLUSH and REDIR, and resets to IDLE.
REQ-021 IDLE transitions to FLUSH on the cycle after an accepted mispredict; a correct prediction keeps the FSM in IDLE.
REQ-022 In FLUSH, flush is 1 for exactly one cycle, then the FSM moves to REDIR.
REQ-023 In REDIR, redirect_valid is 1 and redirect_pc holds the latched br_target until redirect_ready; the FSM then returns to IDLE.
REQ-024 redirect_pc is stable while redirect_valid is 1 and ready is 0.
REQ-025 br_ready = (state == IDLE) & !fifo_full; a push in the same cycle as a pop on a full FIFO is not accepted.
REQ-026 Every accepted branch pushes {br_pc, br_taken, br_target} into the FIFO, mispredicted or not.
REQ-027 upd_valid = !fifo_empty; the head pops when upd_valid & upd_ready.
REQ-028 The FIFO drains independently of the FSM state.
REQ-029 Pointers are log2(UPD_DEPTH)+1 bits; full and empty are decided by the MSB and index compare.
REQ-030 Pointers wrap modulo 2*UPD_DEPTH.
REQ-031 Push and pop in the same cycle on a non-empty, non-full FIFO keep the occupancy unchanged.
REQ-032 Latency: accepted mispredict to flush is 1 cycle; to the first redirect_valid is 2 cycles.
REQ-033 flush and redirect_valid are registered outputs.

Reset
REQ-034 On rst, state returns to IDLE; flush, redirect_valid and upd_valid go to 0; redirect_pc goes to 0; FIFO pointers go to 0; stat counters go to 0.
REQ-035 rst asserted mid-FLUSH or mid-REDIR abandons the redirect.
REQ-036 All FIFO entries are discarded on rst.

Configuration
REQ-037 With BRANCH_CTRL_STAT_EN defined, stat_br increments on each accepted branch and stat_mis on each accepted mispredict.
REQ-038 Both stat counters wrap at 2^32.
REQ-039 Without BRANCH_CTRL_STAT_EN, stat_br and stat_mis are constant 0 and no counter registers exist.

Structure
REQ-040 The shared constants file holds DATA_WID, the bctrl_state_t enum (IDLE, FLUSH, REDIR) and the bru_upd_t struct {pc, taken, target}.
REQ-041 The FIFO is sub-module bru_upd_fifo, parameterised by UPD_DEPTH and carrying bru_upd_t.

Verification
REQ-042 Correct-predict test: pc=0x100, taken=1, target=0x140, pred 1/0x140.
- Required: no flush, br_ready stays 1, one update entry {0x100,1,0x140}.
REQ-043 Direction mispredict: pc=0x200, taken=0, target=0x204, pred_taken=1, redirect_ready=1.
- Required: flush at T+1, redirect_valid with redirect_pc=0x204 at T+2, IDLE at T+3.
REQ-044 Target mispredict with redirect_ready held 0 for 5 cycles: taken=1, target=0x300, pred 1/0x280.
- Required: redirect_pc=0x300 stable, br_ready=0 throughout, single flush pulse.
REQ-045 Full FIFO: upd_ready=0, 4 correct branches accepted.
- Required: br_ready=0 on the 5th; one upd_ready pulse re-opens br_ready the next cycle; FIFO order preserved across wrap.
REQ-046 rst pulse during REDIR:
- Required: redirect_valid=0 immediately, upd_valid=0, state IDLE, br_ready=1 after reset release.
REQ-047 With BRANCH_CTRL_STAT_EN: 10 branches, 3 mispredicted.
- Required: stat_br=10, stat_mis=3; without the macro, both read 0.
